df_adder_arbiter: RTL and testbench
===================================

# df_adder_arbiter

Round-robin arbiter that shares one saturating adder stage between `NREQ` requesters in the digital-filter datapath. Each requester presents a 9-bit operand pair. The block grants at most one requester per cycle and computes the clamped 8-bit sum. It returns the sum through a registered result port with a valid/ready handshake, tagged with the requester index, and counts saturation events for filter-level overflow monitoring.

## Interface
- `NREQ`, 4: number of requesters; must be 4 in this revision; `res_id_o` is 2 bits.
- `W_IN`, 9: operand width, unsigned.
- `W_OUT`, 8: result width, unsigned; saturation limit is 2^W_OUT-1 = 255.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_i`  in  NREQ  per-requester request; bit k belongs to requester k.
- `a_i`  in  NREQ*W_IN  operand A; requester k uses bits [k*9+8 : k*9].
- `b_i`  in  NREQ*W_IN  operand B, packed the same way as `a_i`.
- `gnt_o`  out  NREQ  one-hot grant, combinational; a transfer occurs when `req_i[k] & gnt_o[k]`.
- `res_valid_o`  out  1  result register holds an unconsumed result.
- `res_ready_i`  in  1  consumer accepts the result this cycle.
- `res_o`  out  W_OUT  saturated sum.
- `res_id_o`  out  2  index of the requester that produced `res_o`.
- `sat_o`  out  1  set when the sum was clamped (a+b > 255).
- `sat_cnt_o`  out  8  count of accepted saturated results; sticks at 255.

## Operation
- **Arithmetic**
  - The full sum a+b is computed at 10 bits (maximum 1022).
  - `res_o` = min(a+b, 255); `sat_o` = (a+b > 255).
- **Request protocol**
  - A requester holds `req_i[k]` high with stable operands until it sees `gnt_o[k]` high.
  - It may drop the request in the cycle after the grant.
- **Grant conditions**
  - `free` = !res_valid_o | res_ready_i.
  - `gnt_o` is nonzero only when `reset_n`=1, `free`=1 and `req_i`≠0.
  - At most one grant bit is set at a time.
- **Round-robin selection**
  - A 2-bit pointer `ptr` names the highest-priority index.
  - The search order is ptr, ptr+1, … mod 4.
  - After a grant to index k, `ptr` becomes (k+1) mod 4.
  - `ptr` is unchanged in cycles with no grant.
- **Result register**
  - On a grant, the next clock loads `res_o`, `sat_o` and `res_id_o`, and sets `res_valid_o`=1.
  - If the result is consumed (`res_valid_o & res_ready_i`) with no new grant in the same cycle, `res_valid_o` clears and the data fields hold their last value.
  - Consume and new grant in the same cycle: the register reloads and `res_valid_o` stays 1 (back-to-back throughput).
- **Backpressure**
  - While `res_valid_o`=1 and `res_ready_i`=0, all result outputs are held stable and `gnt_o`=0.
- **Saturation counter**
  - `sat_cnt_o` increments when a result with `sat_o`=1 is consumed.
  - It saturates at 255 and does not wrap.
- **Reset**
  - Every cycle with `reset_n`=0 forces: `gnt_o`=0, `res_valid_o`=0, `res_o`=0, `res_id_o`=0, `sat_o`=0, `sat_cnt_o`=0, `ptr`=0.
  - Reset aborts any in-flight result; the pending result is lost, not delivered.

## Timing
- **Latency:** grant in cycle t → result valid in cycle t+1.
- **Throughput:** one operation per cycle while `res_ready_i`=1.
- **Combinational paths:**
  - `req_i` and `res_ready_i` → `gnt_o`.
  - There is no combinational path from operands to outputs.
- **Fairness:** with all four requesters continuously active, each is granted exactly once every 4 grant cycles.
- **First cycle after reset release:** `ptr`=0, so index 0 has top priority.

## Test plan
- **Reset:** `req_i`=1111 with `reset_n`=0 for 3 cycles → `gnt_o`=0000 every cycle; all outputs 0.
- **Single requester:** requester 2 with a=28, b=139, `res_ready_i`=1.
  - Cycle t: `gnt_o`=0100.
  - Cycle t+1: `res_o`=167, `res_id_o`=2, `sat_o`=0, `res_valid_o`=1.
- **Round-robin:** `req_i`=1111 held, `res_ready_i`=1 → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; `res_id_o` follows 0, 1, 2, 3, 0 one cycle later.
- **Saturation:**
  - a=255, b=255 → `res_o`=255, `sat_o`=1.
  - a=256, b=256 → `res_o`=255, `sat_o`=1.
  - a=0, b=0 → `res_o`=0, `sat_o`=0.
  - After all three are consumed, `sat_cnt_o`=2.
  - 300 saturated results → `sat_cnt_o` stays at 255.
- **Backpressure:**
  - Setup: result from requester 1 valid, `res_ready_i`=0 for 3 cycles, `req_i`=0101.
  - During stall: `gnt_o`=0000 and outputs unchanged.
  - Cycle `res_ready_i` rises: `gnt_o`=0100 (ptr=2).
  - Next cycle: `res_id_o`=2.
- **Mid-operation reset:**
  - Setup: `reset_n` pulsed low 1 cycle while `res_valid_o`=1 and `sat_cnt_o`=5.
  - Next cycle: `res_valid_o`=0 and `sat_cnt_o`=0.
  - First grant after release goes to the lowest active index.

Source files
------------

// File: rtl/df_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : df_adder_arbiter
// Purpose : Round-robin arbiter sharing one saturating adder among NREQ
//           requesters, with a registered valid/ready result port.
// Rev     : 1.0
// ============================================================================
module df_adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int W_IN  = 9,
    parameter int W_OUT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*W_IN-1:0] a_i,
    input  logic [NREQ*W_IN-1:0] b_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [W_OUT-1:0]     res_o,
    output logic [1:0]           res_id_o,
    output logic                 sat_o,
    output logic [7:0]           sat_cnt_o
);

    localparam int            ID_W    = 2;
    localparam logic [W_IN:0] SAT_LIM = (W_IN+1)'((1 << W_OUT) - 1);
    localparam logic [7:0]    CNT_MAX = 8'hFF;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [W_OUT-1:0] res_q, res_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             sat_q, sat_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             free;
    logic             any_gnt;
    logic [ID_W-1:0]  sel_idx;
    logic [ID_W-1:0]  cand;
    logic [W_IN-1:0]  a_sel;
    logic [W_IN-1:0]  b_sel;
    logic [W_IN:0]    sum;
    logic             consume;

    assign free    = !valid_q || res_ready_i;
    assign consume = valid_q && res_ready_i;

    // Search starts at ptr and wraps; first active requester wins.
    always_comb begin
        gnt_o   = '0;
        any_gnt = 1'b0;
        sel_idx = '0;
        cand    = '0;
        if (reset_n && free) begin
            for (int i = 0; i < NREQ; i++) begin
                cand = ptr_q + ID_W'(i);
                if (!any_gnt && req_i[cand]) begin
                    any_gnt        = 1'b1;
                    sel_idx        = cand;
                    gnt_o[cand]    = 1'b1;
                end
            end
        end
    end

    assign a_sel = a_i[sel_idx*W_IN +: W_IN];
    assign b_sel = b_i[sel_idx*W_IN +: W_IN];
    assign sum   = {1'b0, a_sel} + {1'b0, b_sel};

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        res_d   = res_q;
        id_d    = id_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        if (any_gnt) begin
            ptr_d   = sel_idx + ID_W'(1);
            valid_d = 1'b1;
            id_d    = sel_idx;
            sat_d   = (sum > SAT_LIM);
            res_d   = (sum > SAT_LIM) ? SAT_LIM[W_OUT-1:0] : sum[W_OUT-1:0];
        end else if (consume) begin
            valid_d = 1'b0;
        end
        // Count only results actually handed to the consumer.
        if (consume && sat_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
            id_q    <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            id_q    <= id_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_valid_o = valid_q;
    assign res_o       = res_q;
    assign res_id_o    = id_q;
    assign sat_o       = sat_q;
    assign sat_cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_df_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_df_adder_arbiter
// Purpose : Directed self-checking bench for df_adder_arbiter.
// Rev     : 1.0
// ============================================================================
module tb_df_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int W_IN  = 9;
    localparam int W_OUT = 8;

    logic                 clk;
    logic                 reset_n;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*W_IN-1:0] a_i;
    logic [NREQ*W_IN-1:0] b_i;
    logic [NREQ-1:0]      gnt_o;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [W_OUT-1:0]     res_o;
    logic [1:0]           res_id_o;
    logic                 sat_o;
    logic [7:0]           sat_cnt_o;

    int checks = 0;
    int errors = 0;

    df_adder_arbiter #(.NREQ(NREQ), .W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .gnt_o       (gnt_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .res_id_o    (res_id_o),
        .sat_o       (sat_o),
        .sat_cnt_o   (sat_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [W_IN-1:0] a, input logic [W_IN-1:0] b);
        a_i[k*W_IN +: W_IN] = a;
        b_i[k*W_IN +: W_IN] = b;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req_i   = '0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req_i       = 4'b1111;
        res_ready_i = 1'b1;
        a_i         = '1;
        b_i         = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            checks++;
            if (gnt_o !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt cycle %0d: got %b want 0000", c, gnt_o);
            end
            checks++;
            if ({res_valid_o, res_o, res_id_o, sat_o, sat_cnt_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: valid=%b res=%0d id=%0d sat=%b cnt=%0d want all 0",
                         c, res_valid_o, res_o, res_id_o, sat_o, sat_cnt_o);
            end
        end
        reset_n = 1'b1;
        req_i   = '0;
        a_i     = '0;
        b_i     = '0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        set_op(2, 9'd28, 9'd139);
        res_ready_i = 1'b1;
        req_i       = 4'b0100;
        #1;
        checks++;
        if (gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_gnt: got %b want 0100", gnt_o);
        end
        tick();
        req_i = '0;
        checks++;
        if (res_valid_o !== 1'b1 || res_o !== 8'd167 || res_id_o !== 2'd2 || sat_o !== 1'b0) begin
            errors++;
            $display("FAIL single_result: valid=%b res=%0d id=%0d sat=%b want 1/167/2/0",
                     res_valid_o, res_o, res_id_o, sat_o);
        end
        tick();
        checks++;
        if (res_valid_o !== 1'b0 || res_o !== 8'd167) begin
            errors++;
            $display("FAIL single_consume: valid=%b res=%0d want 0/167", res_valid_o, res_o);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        apply_reset();
        for (int k = 0; k < NREQ; k++) set_op(k, 9'(k * 10), 9'd1);
        res_ready_i = 1'b1;
        req_i       = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_gnt = 4'b0001 << (i % 4);
            #1;
            checks++;
            if (gnt_o !== exp_gnt) begin
                errors++;
                $display("FAIL rr_gnt step %0d: got %b want %b", i, gnt_o, exp_gnt);
            end
            tick();
            checks++;
            if (res_valid_o !== 1'b1 || res_id_o !== 2'(i % 4) || res_o !== 8'((i % 4) * 10 + 1)) begin
                errors++;
                $display("FAIL rr_result step %0d: valid=%b id=%0d res=%0d want 1/%0d/%0d",
                         i, res_valid_o, res_id_o, res_o, i % 4, (i % 4) * 10 + 1);
            end
        end
        req_i = '0;
        tick();
    endtask

    task automatic test_saturation();
        logic [W_IN-1:0]  va [3];
        logic [W_IN-1:0]  vb [3];
        logic [W_OUT-1:0] vr [3];
        logic             vs [3];
        va = '{9'd255, 9'd256, 9'd0};
        vb = '{9'd255, 9'd256, 9'd0};
        vr = '{8'd255, 8'd255, 8'd0};
        vs = '{1'b1, 1'b1, 1'b0};
        apply_reset();
        res_ready_i = 1'b1;
        for (int v = 0; v < 3; v++) begin
            set_op(0, va[v], vb[v]);
            req_i = 4'b0001;
            tick();
            req_i = '0;
            checks++;
            if (res_valid_o !== 1'b1 || res_o !== vr[v] || sat_o !== vs[v]) begin
                errors++;
                $display("FAIL sat_vec %0d: valid=%b res=%0d sat=%b want 1/%0d/%b",
                         v, res_valid_o, res_o, sat_o, vr[v], vs[v]);
            end
            tick();
        end
        checks++;
        if (sat_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL sat_cnt_after3: got %0d want 2", sat_cnt_o);
        end
        // Back-to-back saturated results: count after n edges is 2 + (n-1).
        set_op(0, 9'd255, 9'd255);
        req_i = 4'b0001;
        for (int n = 0; n < 100; n++) tick();
        checks++;
        if (sat_cnt_o !== 8'd101) begin
            errors++;
            $display("FAIL sat_cnt_mid: got %0d want 101", sat_cnt_o);
        end
        for (int n = 0; n < 200; n++) tick();
        checks++;
        if (sat_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL sat_cnt_clamp: got %0d want 255", sat_cnt_o);
        end
        req_i = '0;
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_op(1, 9'd5, 9'd6);
        set_op(0, 9'd1, 9'd1);
        set_op(2, 9'd20, 9'd30);
        res_ready_i = 1'b0;
        req_i       = 4'b0010;
        tick();
        req_i = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt_o !== 4'b0000) begin
                errors++;
                $display("FAIL bp_gnt_stall cycle %0d: got %b want 0000", c, gnt_o);
            end
            tick();
            checks++;
            if (res_valid_o !== 1'b1 || res_o !== 8'd11 || res_id_o !== 2'd1 || sat_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b res=%0d id=%0d sat=%b want 1/11/1/0",
                         c, res_valid_o, res_o, res_id_o, sat_o);
            end
        end
        res_ready_i = 1'b1;
        #1;
        checks++;
        if (gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_gnt: got %b want 0100", gnt_o);
        end
        tick();
        req_i = '0;
        checks++;
        if (res_valid_o !== 1'b1 || res_id_o !== 2'd2 || res_o !== 8'd50) begin
            errors++;
            $display("FAIL bp_next_result: valid=%b id=%0d res=%0d want 1/2/50",
                     res_valid_o, res_id_o, res_o);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        set_op(0, 9'd255, 9'd255);
        set_op(1, 9'd2, 9'd3);
        set_op(3, 9'd4, 9'd4);
        res_ready_i = 1'b1;
        req_i       = 4'b0001;
        for (int n = 0; n < 6; n++) tick();
        req_i       = '0;
        res_ready_i = 1'b0;
        #1;
        checks++;
        if (res_valid_o !== 1'b1 || sat_cnt_o !== 8'd5) begin
            errors++;
            $display("FAIL midrst_setup: valid=%b cnt=%0d want 1/5", res_valid_o, sat_cnt_o);
        end
        reset_n = 1'b0;
        req_i   = 4'b1111;
        res_ready_i = 1'b1;
        #1;
        checks++;
        if (gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_gnt_in_reset: got %b want 0000", gnt_o);
        end
        tick();
        reset_n = 1'b1;
        req_i   = 4'b1010;
        checks++;
        if (res_valid_o !== 1'b0 || sat_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL midrst_cleared: valid=%b cnt=%0d want 0/0", res_valid_o, sat_cnt_o);
        end
        #1;
        checks++;
        if (gnt_o !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_first_gnt: got %b want 0010", gnt_o);
        end
        tick();
        req_i = '0;
        checks++;
        if (res_valid_o !== 1'b1 || res_id_o !== 2'd1 || res_o !== 8'd5) begin
            errors++;
            $display("FAIL midrst_first_result: valid=%b id=%0d res=%0d want 1/1/5",
                     res_valid_o, res_id_o, res_o);
        end
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        req_i       = '0;
        a_i         = '0;
        b_i         = '0;
        res_ready_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
